// File: rtl/seg7_count_monitor_pkg.sv
// Shared 7-segment definitions: active-low patterns ({g,f,e,d,c,b,a}) and monitor FSM states.
// The counter-side decoder uses the same constants, so both ends agree on the glyphs.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_e;

  // Forward mapping used by the display driver side.
  function automatic logic [6:0] seg_of_digit(input logic [2:0] d);
    logic [6:0] p;
    case (d)
      3'd0:    p = SEG_0;
      3'd1:    p = SEG_1;
      3'd2:    p = SEG_2;
      3'd3:    p = SEG_3;
      3'd4:    p = SEG_4;
      3'd5:    p = SEG_5;
      3'd6:    p = SEG_6;
      default: p = SEG_7;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational inverse of the 7-segment glyph table; modulus legality is left to the caller.
module seg7_to_digit
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       is_digit_o,
  output logic       is_blank_o,
  output logic [2:0] digit_o
);

  always_comb begin
    is_digit_o = 1'b1;
    digit_o    = '0;
    is_blank_o = (pattern_i == SEG_BLANK);
    case (pattern_i)
      SEG_0:   digit_o = 3'd0;
      SEG_1:   digit_o = 3'd1;
      SEG_2:   digit_o = 3'd2;
      SEG_3:   digit_o = 3'd3;
      SEG_4:   digit_o = 3'd4;
      SEG_5:   digit_o = 3'd5;
      SEG_6:   digit_o = 3'd6;
      SEG_7:   digit_o = 3'd7;
      default: is_digit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_count_monitor.sv
// Display-side checker: glitch-filters the active-low seg bus, decodes stable glyphs and
// tracks up/down stepping of the mod-MOD counter, flagging skipped or malformed patterns.
module seg7_count_monitor
  import seg7_pkg::*;
#(
  parameter int MOD        = 6,
  parameter int STABLE_CYC = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    seg,
  output logic [CW-1:0] value,
  output logic          valid,
  output logic          dir,
  output logic          step,
  output logic          skip_err,
  output logic          bad_err,
  output logic [7:0]    net
);

  localparam int CNTW = $clog2(STABLE_CYC + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STABLE_CYC - 1);
  localparam logic [CW-1:0]   DIG_MAX  = CW'(MOD - 1);

  state_e          state_q;
  logic [6:0]      cand_q;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   value_q;
  logic            valid_q;
  logic            dir_q;
  logic            step_q;
  logic            skip_q;
  logic            bad_q;
  logic [7:0]      net_q;

  logic            is_digit;
  logic            is_blank;
  logic [2:0]      digit;
  logic            legal;
  logic [CW-1:0]   dig_cw;
  logic [CW-1:0]   up_val;
  logic [CW-1:0]   dn_val;
  logic            accept;

  seg7_to_digit u_dec (
    .pattern_i  (seg),
    .is_digit_o (is_digit),
    .is_blank_o (is_blank),
    .digit_o    (digit)
  );

  always_comb begin
    legal  = is_digit && (int'(digit) < MOD);
    dig_cw = CW'(digit);
    up_val = (value_q == DIG_MAX) ? '0 : value_q + 1'b1;
    dn_val = (value_q == '0) ? DIG_MAX : value_q - 1'b1;
    accept = (seg == cand_q) && (state_q == SETTLE) && (cnt_q == CNT_LAST);
  end

  // Filter, FSM and compare logic share one register block; the accept edge is the
  // STABLE_CYC-th matching sample, after which LOCKED freezes everything until seg moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cand_q  <= SEG_BLANK;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      skip_q  <= 1'b0;
      bad_q   <= 1'b0;
      net_q   <= '0;
    end else begin
      step_q <= 1'b0;
      skip_q <= 1'b0;
      bad_q  <= 1'b0;
      if (seg != cand_q) begin
        cand_q  <= seg;
        cnt_q   <= CNTW'(1);
        state_q <= SETTLE;
      end else if (state_q == SETTLE) begin
        if (!accept) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (legal) begin
          state_q <= LOCKED;
          value_q <= dig_cw;
          valid_q <= 1'b1;
          if (valid_q) begin
            // Up is tested first so MOD=2, where both neighbours coincide, reads as up.
            if (dig_cw == up_val) begin
              step_q <= 1'b1;
              dir_q  <= 1'b0;
              net_q  <= net_q + 8'd1;
            end else if (dig_cw == dn_val) begin
              step_q <= 1'b1;
              dir_q  <= 1'b1;
              net_q  <= net_q - 8'd1;
            end else if (dig_cw != value_q) begin
              skip_q <= 1'b1;
            end
          end
        end else if (is_blank) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end else begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          bad_q   <= 1'b1;
        end
      end
    end
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign skip_err = skip_q;
  assign bad_err  = bad_q;
  assign net      = net_q;

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Randomized scoreboard bench for seg7_count_monitor (MOD=6, STABLE_CYC=4) with a run-length reference model.
module tb_seg7_count_monitor;

  localparam int MOD    = 6;
  localparam int STABLE = 4;
  localparam int CW     = 3;

  logic          clk;
  logic          rst;
  logic [6:0]    seg;
  logic [CW-1:0] value;
  logic          valid;
  logic          dir;
  logic          step;
  logic          skip_err;
  logic          bad_err;
  logic [7:0]    net;

  seg7_count_monitor #(.MOD(MOD), .STABLE_CYC(STABLE), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .seg      (seg),
    .value    (value),
    .valid    (valid),
    .dir      (dir),
    .step     (step),
    .skip_err (skip_err),
    .bad_err  (bad_err),
    .net      (net)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] value;
    logic       valid;
    logic       dir;
    logic       step;
    logic       skip;
    logic       bad;
    logic [7:0] net;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] pat [8];
  localparam logic [6:0] BLANK = 7'b1111111;

  // Reference model state: last sample, length of its current run, and display-level results.
  logic [6:0] m_prev;
  int         m_run;
  int         m_val;
  bit         m_valid;
  bit         m_dir;
  bit         m_step;
  bit         m_skip;
  bit         m_bad;
  int         m_net;

  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
    pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int glyph_index(input logic [6:0] s);
    for (int i = 0; i < 8; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = BLANK; m_run = STABLE;
    m_val = 0; m_valid = 0; m_dir = 0; m_net = 0;
    m_step = 0; m_skip = 0; m_bad = 0;
  endtask

  task automatic model_sample(input logic [6:0] s);
    int d;
    bit fire;
    m_step = 0; m_skip = 0; m_bad = 0;
    fire = 0;
    if (s == m_prev) begin
      if (m_run < STABLE) begin
        m_run++;
        fire = (m_run == STABLE);
      end
    end else begin
      m_prev = s;
      m_run  = 1;
    end
    if (fire) begin
      d = glyph_index(s);
      if (d >= 0 && d < MOD) begin
        if (m_valid) begin
          if (d == (m_val + 1) % MOD) begin
            m_step = 1; m_dir = 0; m_net = (m_net + 1) % 256;
          end else if (d == (m_val + MOD - 1) % MOD) begin
            m_step = 1; m_dir = 1; m_net = (m_net + 255) % 256;
          end else if (d != m_val) begin
            m_skip = 1;
          end
        end
        m_val = d; m_valid = 1;
      end else if (s == BLANK) begin
        m_valid = 0;
      end else begin
        m_bad = 1; m_valid = 0;
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.value = 3'(m_val); e.valid = m_valid; e.dir = m_dir;
    e.step = m_step; e.skip = m_skip; e.bad = m_bad; e.net = 8'(m_net);
    return e;
  endfunction

  task automatic drive(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      seg = p;
      model_sample(p);
      expq.push_back(snapshot());
    end
  endtask

  task automatic drive_digit(input int d, input int n);
    drive(pat[d], n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    expq.push_back(snapshot());
    #1;
    chk("async_reset_valid", int'(valid), 0);
    chk("async_reset_value", int'(value), 0);
    chk("async_reset_net", int'(net), 0);
    chk("async_reset_pulses", int'({step, skip_err, bad_err, dir}), 0);
  endtask

  // Monitor: every edge the DUT presents a registered result; compare it to the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("value", int'(value), int'(e.value));
        chk("valid", int'(valid), int'(e.valid));
        chk("dir", int'(dir), int'(e.dir));
        chk("step", int'(step), int'(e.step));
        chk("skip_err", int'(skip_err), int'(e.skip));
        chk("bad_err", int'(bad_err), int'(e.bad));
        chk("net", int'(net), int'(e.net));
        chk("one_hot_pulse", int'((32'(step) + 32'(skip_err) + 32'(bad_err)) <= 1), 1);
      end
    end
  end

  initial begin
    int d, n, r, cur;
    rst = 1'b0;
    seg = BLANK;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    drive(BLANK, 3);

    drive_digit(0, 4);
    drive_digit(1, 4);
    drive_digit(2, 4);
    drive_digit(1, 4);
    drive_digit(0, 4);
    drive_digit(5, 4);
    drive_digit(0, 4);
    drive_digit(1, 4);
    drive_digit(2, 4);
    drive_digit(3, 3);
    drive_digit(2, 4);
    drive_digit(1, 4);
    drive_digit(3, 4);
    drive_digit(6, 4);
    drive_digit(4, 2);
    do_reset();
    drive_digit(4, 4);
    drive_digit(4, 3);

    drive_digit(0, 4);
    for (int i = 1; i <= 135; i++) drive_digit(i % MOD, 4);
    for (int i = 0; i < 270; i++) drive_digit((135 * 5 - i - 1 + 6 * 300) % MOD, 4);

    cur = m_val;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      n = int'($urandom_range(1, 6));
      if (r < 3)      d = (m_val + 1) % MOD;
      else if (r < 5) d = (m_val + MOD - 1) % MOD;
      else if (r < 7) d = int'($urandom_range(0, 7));
      else            d = -1;
      if (d >= 0)      drive_digit(d, n);
      else if (r == 7) drive(BLANK, n);
      else             drive(7'($urandom), n);
      if (i == 150) do_reset();
    end
    cur = 0;
    while (expq.size() > 0 && cur < 50) begin
      @(posedge clk);
      cur++;
    end
    #2;
    if (expq.size() > 0) chk("scoreboard_drain", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
